key_event_queue: RTL and testbench
==================================

# key_event_queue

Converts the six debounced track-button levels into a time-stamped stream of press/release events for the judge logic. Sits directly downstream of the per-button debouncers and is the consumer end of their level interface. Captures every level edge per lane, arbitrates lanes round-robin into a FIFO, and presents events on a valid/ready handshake. Lost events are flagged on a sticky overflow bit.

## Interface
- `LANES`, 6, number of tracks; 1..8.
- `TS_W`, 16, timestamp width.
- `DEPTH`, 8, FIFO entries; power of two, ≥2.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-cycle strobe that advances the timestamp counter.
- `lvl`  in  LANES  debounced button levels, synchronous to `clk`; 1 = pressed.
- `evt_valid`  out  1  FIFO head holds an event.
- `evt_ready`  in  1  consumer accepts the head.
- `evt_lane`  out  3  lane index of the head event.
- `evt_press`  out  1  1 = press (0→1 edge), 0 = release (1→0 edge).
- `evt_time`  out  TS_W  timestamp captured at the edge.
- `overflow`  out  1  sticky: an event was dropped.
- `clr_ovf`  in  1  clears `overflow`.

## Operation
- Reset values:
  - `prev`=0, pending=0, `rr`=0, `ts`=0, FIFO empty, `overflow`=0.
  - Outputs: `evt_valid`=0. `evt_lane`, `evt_press` and `evt_time` read 0.
- Timestamp `ts`: increments by 1 on each `tick` and wraps modulo 2^TS_W.
- Edge detect, per lane i: an edge exists when `lvl[i]` != `prev[i]`. `prev[i]` <= `lvl[i]` every cycle.
- Pending slot, one per lane, holding {type, time}:
  - On an edge the slot loads type = `lvl[i]` and time = `ts` as it is in that cycle, before any increment.
  - If the slot is already full and not granted this cycle, the new edge is dropped and `overflow` is set. The old content is kept.
  - If an edge arrives on the same cycle the slot is granted, the granted event enters the FIFO and the new event loads the slot. Nothing is lost.
- Arbiter:
  - When the FIFO is not full, grant the first pending lane found searching upward from `rr`, wrapping at LANES-1.
  - Write the granted lane's event into the FIFO, clear its slot, and set `rr` = granted+1 mod LANES.
  - At most one grant per cycle.
  - When the FIFO is full there is no grant and slots hold their events. Backpressure alone never drops an event.
- FIFO:
  - First-word fall-through; `evt_*` show the head combinationally from storage.
  - `evt_valid` = not empty. A pop occurs on `evt_valid & evt_ready`.
  - Push and pop in the same cycle leave the count unchanged.
  - "Full" is evaluated at the start of the cycle, so a pop does not enable a push in the same cycle.
- `overflow`: set on any drop and cleared by `clr_ovf`. If a drop and `clr_ovf` occur in the same cycle, set wins.
- Reset mid-operation: all state clears immediately.
  - Because `prev` resets to 0, a lane held through reset produces a press event after reset is released.

## Timing
- Edge sampled at rising edge k: the slot is loaded at edge k. If there is no contention and the FIFO is not full, the event is written at edge k+1 and `evt_valid` is high from k+1.
  - Latency is 2 cycles from the `lvl` change to `evt_valid`.
- N lanes with simultaneous edges reach the FIFO on N consecutive cycles, in round-robin order.
- Throughput is 1 event per cycle in and 1 per cycle out.
- `evt_*` stay stable while `evt_valid` is high and `evt_ready` is low.

## Test plan
- **Single press:**
  - Stimulus: `ts`=5; `lvl[3]` 0→1, held 20 cycles, then 1→0 with `ts`=9.
  - Required: two events, (lane 3, press, 5) then (lane 3, release, 9). `evt_valid` rises 2 cycles after each edge.
- **Simultaneous lanes after reset:**
  - Stimulus: `lvl` 000000→100101 in one cycle, `evt_ready`=1.
  - Required: lanes 0, 2, 5 on three consecutive cycles, all with the same time.
- **Backpressure:**
  - Stimulus: `evt_ready`=0; toggle lanes to generate 10 single edges across distinct lanes/cycles.
  - Required: 8 events queued and the other 2 held pending. `overflow` stays 0. After `evt_ready`=1, all 10 come out in order.
- **Overflow:**
  - Stimulus: FIFO full; lane 1 presses, then releases 5 cycles later.
  - Required: release dropped and `overflow`=1. After the drain, only the press is delivered for lane 1. `clr_ovf` clears the flag.
- **Timestamp wrap:**
  - Stimulus: TS_W=16, `ts`=0xFFFF; a `tick` and a lane-0 edge in the same cycle.
  - Required: event time 0xFFFF. The next edge gets 0x0000.
- **Reset while held:**
  - Stimulus: `lvl[4]`=1 and FIFO holding 3 events; pulse `rst_n` low.
  - Required: `evt_valid`=0 immediately. After release, a single event (lane 4, press, 0) appears.

Source files
------------

// File: rtl/key_event_queue.sv
// key_event_queue: converts debounced lane levels into time-stamped press/release
// events, arbitrated round-robin into a first-word fall-through FIFO.
module key_event_queue #(
  parameter int LANES = 6,
  parameter int TS_W  = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [LANES-1:0] lvl,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [2:0]       evt_lane,
  output logic             evt_press,
  output logic [TS_W-1:0]  evt_time,
  output logic             overflow,
  input  logic             clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = TS_W + 4;

  logic [TS_W-1:0]  ts;
  logic [LANES-1:0] prev;
  logic [LANES-1:0] edge_det;
  logic [LANES-1:0] pend;
  logic [LANES-1:0] pend_type;
  logic [TS_W-1:0]  pend_time [LANES];
  logic [LANES-1:0] gnt_hit;
  logic [LANES-1:0] load;
  logic [LANES-1:0] drop;

  logic [2:0]       rr;
  logic [2:0]       gnt;
  logic [2:0]       scan;
  logic             gnt_vld;

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             push;
  logic             pop;
  logic [EW-1:0]    head;

  function automatic logic [2:0] lane_inc(input logic [2:0] l);
    if (l == 3'(LANES - 1)) return 3'd0;
    return l + 3'd1;
  endfunction

  // Stage 0: edge detect against the previous cycle's level
  assign edge_det = lvl ^ prev;

  assign full = (count == (AW + 1)'(DEPTH));
  assign push = gnt_vld;
  assign pop  = evt_valid & evt_ready;

  // Round-robin scan starting at rr; full is the start-of-cycle state
  always_comb begin
    gnt     = 3'd0;
    gnt_vld = 1'b0;
    scan    = rr;
    for (int k = 0; k < LANES; k++) begin
      if (!gnt_vld && pend[scan]) begin
        gnt     = scan;
        gnt_vld = 1'b1;
      end
      scan = lane_inc(scan);
    end
    if (full) gnt_vld = 1'b0;
  end

  // A granted slot frees up in the same cycle, so a new edge can reload it
  always_comb begin
    gnt_hit = '0;
    load    = '0;
    drop    = '0;
    for (int i = 0; i < LANES; i++) begin
      gnt_hit[i] = gnt_vld && (gnt == 3'(i));
      load[i]    = edge_det[i] && (!pend[i] || gnt_hit[i]);
      drop[i]    = edge_det[i] && pend[i] && !gnt_hit[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts       <= '0;
      prev     <= '0;
      pend     <= '0;
      rr       <= 3'd0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (tick) ts <= ts + TS_W'(1);
      prev <= lvl;
      pend <= (pend & ~gnt_hit) | load;
      if (push) begin
        rr     <= lane_inc(gnt);
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      if (|drop)        overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  // Stage 1: pending slot payload and FIFO storage
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (load[i]) begin
        pend_type[i] <= lvl[i];
        pend_time[i] <= ts;
      end
    end
    if (push) mem[wr_ptr] <= {gnt, pend_type[gnt], pend_time[gnt]};
  end

  // Stage 2: fall-through head, forced to zero while empty
  assign head      = mem[rd_ptr];
  assign evt_valid = (count != '0);
  assign evt_lane  = evt_valid ? head[EW-1 -: 3] : 3'd0;
  assign evt_press = evt_valid ? head[TS_W] : 1'b0;
  assign evt_time  = evt_valid ? head[TS_W-1:0] : '0;

endmodule

// File: tb/tb_key_event_queue.sv
// Bench for key_event_queue: directed scenarios plus a randomized run
// compared against a queue-based behavioural model.
module tb_key_event_queue;

  localparam int LANES = 6;
  localparam int TS_W  = 16;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tick = 1'b0;
  logic [LANES-1:0] lvl = '0;
  logic             evt_valid;
  logic             evt_ready = 1'b0;
  logic [2:0]       evt_lane;
  logic             evt_press;
  logic [TS_W-1:0]  evt_time;
  logic             overflow;
  logic             clr_ovf = 1'b0;

  int checks = 0;
  int errors = 0;

  key_event_queue #(.LANES(LANES), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .lvl(lvl),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_lane(evt_lane),
    .evt_press(evt_press), .evt_time(evt_time),
    .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  // Behavioural reference: event queue, per-lane slot, rotating pointer
  typedef struct packed {
    logic [2:0]  lane;
    logic        press;
    logic [15:0] t;
  } ev_t;

  ev_t         m_q[$];
  logic [5:0]  m_prev, m_pend, m_ptype;
  logic [15:0] m_ptime [LANES];
  int          m_rr;
  logic [15:0] m_ts;
  logic        m_ovf;

  function automatic logic [20:0] mk(input logic v, input logic [2:0] l,
                                     input logic p, input logic [15:0] t);
    return {v, l, p, t};
  endfunction

  function automatic logic [20:0] obs();
    return {evt_valid, evt_lane, evt_press, evt_time};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_prev = '0; m_pend = '0; m_ptype = '0;
    for (int i = 0; i < LANES; i++) m_ptime[i] = '0;
    m_rr = 0; m_ts = '0; m_ovf = 1'b0;
  endtask

  task automatic model_step();
    bit   was_full;
    bit   dropped;
    int   lane;
    ev_t  e;
    was_full = (m_q.size() >= DEPTH);
    dropped  = 1'b0;
    if (m_q.size() > 0 && evt_ready) m_q.delete(0);
    if (!was_full) begin
      for (int k = 0; k < LANES; k++) begin
        lane = (m_rr + k) % LANES;
        if (m_pend[lane]) begin
          e.lane = 3'(lane); e.press = m_ptype[lane]; e.t = m_ptime[lane];
          m_q.push_back(e);
          m_pend[lane] = 1'b0;
          m_rr = (lane + 1) % LANES;
          break;
        end
      end
    end
    for (int i = 0; i < LANES; i++) begin
      if (lvl[i] != m_prev[i]) begin
        if (m_pend[i]) dropped = 1'b1;
        else begin
          m_pend[i] = 1'b1; m_ptype[i] = lvl[i]; m_ptime[i] = m_ts;
        end
      end
    end
    if (dropped) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
    if (tick) m_ts = m_ts + 16'd1;
    m_prev = lvl;
  endtask

  task automatic cyc();
    if (!rst_n) model_reset();
    else model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; lvl = '0; tick = 1'b0; evt_ready = 1'b0; clr_ovf = 1'b0;
    model_reset();
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; lvl = '0; tick = 1'b0; evt_ready = 1'b0; clr_ovf = 1'b0;
    model_reset();
    #2;
    checks++;
    if (obs() !== mk(1'b0, 3'd0, 1'b0, 16'h0)) begin
      errors++; $display("FAIL rst_outputs: got %h expected %h", obs(), mk(1'b0, 3'd0, 1'b0, 16'h0));
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL rst_overflow: got %b expected 0", overflow);
    end
    cyc(); cyc();
    rst_n = 1'b1;
    cyc(); cyc(); cyc();
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL rst_idle_valid: got %b expected 0", evt_valid);
    end
  endtask

  task automatic test_single_press();
    do_reset();
    repeat (5) begin tick = 1'b1; cyc(); end
    tick = 1'b0;
    lvl[3] = 1'b1;
    cyc();
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL sp_press_early: got %b expected 0", evt_valid);
    end
    cyc();
    checks++;
    if (obs() !== mk(1'b1, 3'd3, 1'b1, 16'd5)) begin
      errors++; $display("FAIL sp_press: got %h expected %h", obs(), mk(1'b1, 3'd3, 1'b1, 16'd5));
    end
    cyc();
    checks++;
    if (obs() !== mk(1'b1, 3'd3, 1'b1, 16'd5)) begin
      errors++; $display("FAIL sp_press_stable: got %h expected %h", obs(), mk(1'b1, 3'd3, 1'b1, 16'd5));
    end
    evt_ready = 1'b1; cyc(); evt_ready = 1'b0;
    repeat (4) begin tick = 1'b1; cyc(); end
    tick = 1'b0;
    repeat (12) cyc();
    lvl[3] = 1'b0;
    cyc();
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL sp_release_early: got %b expected 0", evt_valid);
    end
    cyc();
    checks++;
    if (obs() !== mk(1'b1, 3'd3, 1'b0, 16'd9)) begin
      errors++; $display("FAIL sp_release: got %h expected %h", obs(), mk(1'b1, 3'd3, 1'b0, 16'd9));
    end
    evt_ready = 1'b1; cyc(); evt_ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    int exp_lane[3];
    exp_lane = '{0, 2, 5};
    do_reset();
    repeat (3) begin tick = 1'b1; cyc(); end
    tick = 1'b0;
    evt_ready = 1'b1;
    lvl = 6'b100101;
    cyc();
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL sim_early: got %b expected 0", evt_valid);
    end
    for (int j = 0; j < 3; j++) begin
      cyc();
      checks++;
      if (obs() !== mk(1'b1, 3'(exp_lane[j]), 1'b1, 16'd3)) begin
        errors++; $display("FAIL sim_lane%0d: got %h expected %h", j, obs(), mk(1'b1, 3'(exp_lane[j]), 1'b1, 16'd3));
      end
    end
    cyc();
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL sim_empty: got %b expected 0", evt_valid);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int el[10];
    int ep[10];
    int n;
    el = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3};
    ep = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    do_reset();
    for (int j = 0; j < 10; j++) begin
      lvl[el[j]] = ep[j][0];
      tick = 1'b1; cyc(); tick = 1'b0; cyc();
    end
    repeat (5) cyc();
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL bp_overflow: got %b expected 0", overflow);
    end
    evt_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      n = 0;
      while (!evt_valid && n < 20) begin cyc(); n++; end
      checks++;
      if (obs() !== mk(1'b1, 3'(el[j]), ep[j][0], 16'(j))) begin
        errors++; $display("FAIL bp_ev%0d: got %h expected %h", j, obs(), mk(1'b1, 3'(el[j]), ep[j][0], 16'(j)));
      end
      cyc();
    end
    repeat (3) cyc();
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drained: got %b expected 0", evt_valid);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_overflow();
    int el[9];
    int ep[9];
    int n;
    el = '{0, 2, 3, 4, 5, 0, 2, 3, 1};
    ep = '{1, 1, 1, 1, 1, 0, 0, 0, 1};
    do_reset();
    for (int j = 0; j < 8; j++) begin
      lvl[el[j]] = ep[j][0];
      tick = 1'b1; cyc(); tick = 1'b0; cyc();
    end
    repeat (2) cyc();
    lvl[1] = 1'b1;
    cyc();
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_press_kept: got %b expected 0", overflow);
    end
    repeat (4) cyc();
    lvl[1] = 1'b0;
    cyc();
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_set: got %b expected 1", overflow);
    end
    evt_ready = 1'b1;
    for (int j = 0; j < 9; j++) begin
      n = 0;
      while (!evt_valid && n < 20) begin cyc(); n++; end
      checks++;
      if (obs() !== mk(1'b1, 3'(el[j]), ep[j][0], 16'(j))) begin
        errors++; $display("FAIL ovf_ev%0d: got %h expected %h", j, obs(), mk(1'b1, 3'(el[j]), ep[j][0], 16'(j)));
      end
      cyc();
    end
    repeat (4) cyc();
    checks++;
    if ({evt_valid, overflow} !== 2'b01) begin
      errors++; $display("FAIL ovf_after_drain: got valid,ovf=%b expected 01", {evt_valid, overflow});
    end
    clr_ovf = 1'b1; cyc(); clr_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: got %b expected 0", overflow);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_ts_wrap();
    do_reset();
    tick = 1'b1;
    repeat (65535) cyc();
    lvl[0] = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
    checks++;
    if (obs() !== mk(1'b1, 3'd0, 1'b1, 16'hFFFF)) begin
      errors++; $display("FAIL wrap_ffff: got %h expected %h", obs(), mk(1'b1, 3'd0, 1'b1, 16'hFFFF));
    end
    evt_ready = 1'b1; cyc(); evt_ready = 1'b0;
    lvl[0] = 1'b0;
    cyc(); cyc();
    checks++;
    if (obs() !== mk(1'b1, 3'd0, 1'b0, 16'h0000)) begin
      errors++; $display("FAIL wrap_0000: got %h expected %h", obs(), mk(1'b1, 3'd0, 1'b0, 16'h0000));
    end
    evt_ready = 1'b1; cyc(); evt_ready = 1'b0;
  endtask

  task automatic test_reset_held();
    do_reset();
    tick = 1'b1;
    lvl[4] = 1'b1; cyc();
    lvl[0] = 1'b1; cyc();
    lvl[0] = 1'b0; cyc();
    tick = 1'b0;
    repeat (3) cyc();
    checks++;
    if (evt_valid !== 1'b1) begin
      errors++; $display("FAIL rh_filled: got %b expected 1", evt_valid);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs() !== mk(1'b0, 3'd0, 1'b0, 16'h0)) begin
      errors++; $display("FAIL rh_async_clear: got %h expected %h", obs(), mk(1'b0, 3'd0, 1'b0, 16'h0));
    end
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL rh_early: got %b expected 0", evt_valid);
    end
    cyc();
    checks++;
    if (obs() !== mk(1'b1, 3'd4, 1'b1, 16'h0)) begin
      errors++; $display("FAIL rh_press: got %h expected %h", obs(), mk(1'b1, 3'd4, 1'b1, 16'h0));
    end
    evt_ready = 1'b1;
    repeat (5) cyc();
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++; $display("FAIL rh_single: got %b expected 0", evt_valid);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [5:0] flip;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < LANES; b++) flip[b] = ($urandom % 8 == 0);
      lvl       = lvl ^ flip;
      tick      = ($urandom % 3 == 0);
      evt_ready = ((c / 64) % 2 == 1) ? ($urandom % 2 == 0) : ($urandom % 8 == 0);
      clr_ovf   = ($urandom % 24 == 0);
      cyc();
      checks++;
      if (evt_valid !== (m_q.size() > 0)) begin
        errors++; $display("FAIL rnd_valid c%0d: got %b expected %b", c, evt_valid, (m_q.size() > 0));
      end
      if (m_q.size() > 0) begin
        checks++;
        if (obs() !== mk(1'b1, m_q[0].lane, m_q[0].press, m_q[0].t)) begin
          errors++; $display("FAIL rnd_head c%0d: got %h expected %h", c, obs(), mk(1'b1, m_q[0].lane, m_q[0].press, m_q[0].t));
        end
      end
      checks++;
      if (overflow !== m_ovf) begin
        errors++; $display("FAIL rnd_overflow c%0d: got %b expected %b", c, overflow, m_ovf);
      end
    end
    clr_ovf = 1'b0; evt_ready = 1'b0; tick = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_simultaneous();
    test_backpressure();
    test_overflow();
    test_ts_wrap();
    test_reset_held();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
